// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the loader.
// master = the loader (consumes bytes, drives memory); slave = stream source / memory side.
interface imem_loader_if;
  // A byte moves on a rising edge where rx_valid && rx_ready; the source holds rx_data until then.
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wd
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: takes a count byte plus 4*N little-endian data bytes, writes them to
// instruction memory, zero-fills the rest, and releases cpu_hold only on a clean image.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [7:0]          words_loaded,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    FILL  = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  words_q, words_d;
  logic        rx_ready_q, rx_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic [7:0]  idx_inc;

  assign accept  = bus.rx_valid && rx_ready_q;
  assign idx_inc = word_idx_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    words_d    = words_q;
    mem_we_d   = 1'b0;
    mem_addr_d = 32'd0;
    mem_wd_d   = 32'd0;

    case (state_q)
      IDLE: begin
        if (start) state_d = COUNT;
      end
      COUNT: begin
        if (accept) begin
          if (bus.rx_data == 8'd0 || {1'b0, bus.rx_data} > DEPTH_W) begin
            state_d = ERROR;
          end else begin
            n_d        = bus.rx_data;
            word_idx_d = 8'd0;
            byte_idx_d = 2'd0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          // Bytes shift in from the top so the first one ends up in the low lane.
          asm_d      = {bus.rx_data, asm_q[23:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d    = WRITE;
            mem_we_d   = 1'b1;
            mem_addr_d = {22'd0, word_idx_q, 2'b00};
            mem_wd_d   = {bus.rx_data, asm_q};
          end
        end
      end
      WRITE: begin
        word_idx_d = idx_inc;
        words_d    = words_q + 8'd1;
        if (idx_inc == n_q) begin
          if ({1'b0, n_q} < DEPTH_W) begin
            state_d    = FILL;
            mem_we_d   = 1'b1;
            mem_addr_d = {22'd0, idx_inc, 2'b00};
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = DATA;
        end
      end
      FILL: begin
        word_idx_d = idx_inc;
        if (word_idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = {22'd0, idx_inc, 2'b00};
        end
      end
      DONE, ERROR: begin
        if (start) begin
          state_d = COUNT;
          words_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status flags are decoded from the next state so they change on the same edge as the state.
    rx_ready_d = (state_d == COUNT) || (state_d == DATA);
    busy_d     = (state_d == COUNT) || (state_d == DATA) ||
                 (state_d == WRITE) || (state_d == FILL);
    cpu_hold_d = (state_d != DONE);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= 8'd0;
      word_idx_q <= 8'd0;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'd0;
      words_q    <= 8'd0;
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_wd_q   <= 32'd0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      words_q    <= words_d;
      rx_ready_q <= rx_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wd    = mem_wd_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_loaded  = words_q;
  assign dbg_state     = state_q;

endmodule
